// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared fetch/decode pipeline types: bubble instruction,
//               skid-buffer state encoding and the IF/ID payload layout.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    // addi x0,x0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } if_id_payload_t;

endpackage
`default_nettype wire

// File: rtl/if_id_skid_reg_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_reg_if
// Description : Fetch-side and decode-side handshake bundle of the IF/ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_skid_reg_if #(
    parameter int XLEN = pipe_pkg::PC_W,
    parameter int ILEN = pipe_pkg::INSTR_W
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [ILEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;

    modport master (
        output flush, in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );
endinterface
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One payload+valid register with load/clear enables.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_load,
    input  wire logic             i_clear,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q,
    output logic                  o_valid
);
    import pipe_pkg::*;

    logic [WIDTH-1:0] r_q;
    logic             r_valid;

    // clear wins over load so a flush always empties the slot
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q     <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_q     <= i_d;
            r_valid <= 1'b1;
        end
    end

    assign o_q     = r_q;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/if_id_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid_reg
// Description : IF/ID stage register as a 2-entry skid buffer with registered
//               in_ready. Define IF_ID_STALL_CNT_EN to add the stall_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid_reg #(
    parameter int              XLEN      = 32,
    parameter int              ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
    input  wire logic               clk,
    input  wire logic               rst,
    if_id_skid_reg_if.slave         bus
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic         [31:0]     stall_cnt
`endif
);
    import pipe_pkg::*;

    localparam int c_payload_w = XLEN + ILEN;

    skid_state_t            r_state;
    skid_state_t            w_state_nxt;
    logic                   r_in_ready;
    logic                   w_in_fire;
    logic                   w_out_fire;
    logic                   w_out_valid;
    logic                   w_main_load;
    logic                   w_main_clr;
    logic                   w_skid_load;
    logic                   w_skid_clr;
    logic                   w_main_valid;
    logic                   w_skid_valid;
    logic [c_payload_w-1:0] w_in_payload;
    logic [c_payload_w-1:0] w_main_d;
    logic [c_payload_w-1:0] w_main_q;
    logic [c_payload_w-1:0] w_skid_q;

    assign w_in_payload = {bus.in_pc, bus.in_instr};
    assign w_in_fire    = bus.in_valid & r_in_ready;
    assign w_out_valid  = w_main_valid & ~bus.flush;
    assign w_out_fire   = w_out_valid & bus.out_ready;
    // a valid skid entry is always older than anything on the input side
    assign w_main_d     = w_skid_valid ? w_skid_q : w_in_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_main_load = 1'b0;
        w_main_clr  = 1'b0;
        w_skid_load = 1'b0;
        w_skid_clr  = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_BUSY;
                    w_main_load = 1'b1;
                end
            end
            ST_BUSY: begin
                if (w_in_fire && w_out_fire) begin
                    w_main_load = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_skid_load = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_clr  = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_out_fire) begin
                    w_state_nxt = ST_BUSY;
                    w_main_load = 1'b1;
                    w_skid_clr  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_main_clr  = 1'b1;
                w_skid_clr  = 1'b1;
            end
        endcase
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_load = 1'b0;
            w_skid_load = 1'b0;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end
    end

    pipe_slot #(.WIDTH(c_payload_w)) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_main_load),
        .i_clear (w_main_clr),
        .i_d     (w_main_d),
        .o_q     (w_main_q),
        .o_valid (w_main_valid)
    );

    pipe_slot #(.WIDTH(c_payload_w)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clr),
        .i_d     (w_in_payload),
        .o_q     (w_skid_q),
        .o_valid (w_skid_valid)
    );

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = w_main_q[c_payload_w-1 -: XLEN];
    assign bus.out_instr = w_out_valid ? w_main_q[ILEN-1:0] : NOP_INSTR;

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_main_valid && !bus.out_ready && !bus.flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_skid_reg
// Description : Directed self-checking bench for the IF/ID skid register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    if_id_skid_reg_if #(.XLEN(32), .ILEN(32)) bus ();

`ifdef IF_ID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    if_id_skid_reg #(.XLEN(32), .ILEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'hA500_0000 | pc;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = ins(pc);
        bus.out_ready = rdy;
        bus.flush     = fl;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL reset_instr got %h want 00000013", bus.out_instr); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
        cyc();
    endtask

    task automatic test_streaming();
        if_id_payload_t exp;
        for (int k = 0; k < 5; k++) begin
            drive(k < 4, 32'(4 * k), 1'b1, 1'b0);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready%0d got %b want 1", k, bus.in_ready); end
            checks++; if (bus.out_valid !== (k > 0)) begin errors++; $display("FAIL stream_valid%0d got %b want %b", k, bus.out_valid, (k > 0)); end
            if (k > 0) begin
                exp.pc    = 32'(4 * (k - 1));
                exp.instr = ins(exp.pc);
                checks++; if ({bus.out_pc, bus.out_instr} !== exp) begin errors++; $display("FAIL stream_data%0d got %h/%h want %h/%h", k, bus.out_pc, bus.out_instr, exp.pc, exp.instr); end
            end
            cyc();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_first_valid got %b want 0", bus.out_valid); end
        cyc();
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_busy_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_pc !== 32'h10 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_busy_out got %h/%b want 10/1", bus.out_pc, bus.out_valid); end
        cyc();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'h99, 1'b0, 1'b0);
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready%0d got %b want 0", k, bus.in_ready); end
            checks++; if (bus.out_pc !== 32'h10 || bus.out_instr !== ins(32'h10) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_full_hold%0d got %h/%h want 10/%h", k, bus.out_pc, bus.out_instr, ins(32'h10)); end
            cyc();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_pc !== 32'h10 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_rel_first got %h/%b want 10/1", bus.out_pc, bus.out_valid); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_rel_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_pc !== 32'h14 || bus.out_instr !== ins(32'h14) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_rel_second got %h/%h want 14/%h", bus.out_pc, bus.out_instr, ins(32'h14)); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h14, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h18, 1'b0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL flush_mask got %b/%h want 0/00000013", bus.out_valid, bus.out_instr); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_after_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_after_ready got %b want 1", bus.in_ready); end
        cyc();
        drive(1'b1, 32'h40, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_stale got %b want 0", bus.out_valid); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== ins(32'h40)) begin errors++; $display("FAIL flush_next got %b/%h/%h want 1/40/%h", bus.out_valid, bus.out_pc, bus.out_instr, ins(32'h40)); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_alone got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 32'h20, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h24, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h20) begin errors++; $display("FAIL b2b_head got %b/%h want 1/20", bus.out_valid, bus.out_pc); end
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_no_full got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h24 || bus.out_instr !== ins(32'h24)) begin errors++; $display("FAIL b2b_next got %b/%h/%h want 1/24/%h", bus.out_valid, bus.out_pc, bus.out_instr, ins(32'h24)); end
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
    endtask

    task automatic test_rst_in_full();
        drive(1'b1, 32'h30, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h34, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rstfull_pre got %b want 0", bus.in_ready); end
        rst = 1'b1;
        drive(1'b1, 32'h38, 1'b1, 1'b1);
        cyc();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstfull_hs got %b/%b want 0/1", bus.out_valid, bus.in_ready); end
        checks++; if (bus.out_pc !== 32'h0 || bus.out_instr !== 32'h0000_0013) begin errors++; $display("FAIL rstfull_data got %h/%h want 0/00000013", bus.out_pc, bus.out_instr); end
`ifdef IF_ID_STALL_CNT_EN
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rstfull_cnt got %0d want 0", stall_cnt); end
`endif
    endtask

    task automatic test_stall_cnt();
`ifdef IF_ID_STALL_CNT_EN
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        cyc();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            cyc();
        end
        drive(1'b1, 32'h54, 1'b0, 1'b1);
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_count got %0d want 3", stall_cnt); end
        cyc();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_after_flush got %0d want 3", stall_cnt); end
        cyc();
        checks++; if (stall_cnt !== 32'd3) begin errors++; $display("FAIL stall_retained got %0d want 3", stall_cnt); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_rst_in_full();
        test_stall_cnt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
